// File: rtl/shift_sched.sv
// shift_sched -- two-requester parallel-to-serial transfer scheduler.
//
// Two requesters each present a WIDTH-bit word. A round-robin arbiter picks
// one in IDLE. Its word is captured into a shift register and sent out LSB
// first on sout_o, qualified by sen_o. One DONE cycle follows each transfer.
//
// Handshake: a requester raises req and holds its data stable until the
// matching ack pulses for one cycle. That ack cycle is also the cycle of the
// first serial bit. Requests raised while busy stay pending and are
// arbitrated in the next IDLE cycle.
//
// Optional feature: define SHIFT_SCHED_PARITY_EN to append an even-parity bit
// after the data bits. The parity is the XOR of the captured word.
//
// Ports:
//   clk160_i          clock, rising edge
//   rst_i             asynchronous active-high reset
//   req0_i / data0_i  requester 0 request and parallel word
//   req1_i / data1_i  requester 1 request and parallel word
//   ack0_o / ack1_o   one-cycle accept pulses
//   grant_o           index of the requester owning the current transfer
//   sen_o / sout_o    serial enable and serial data (LSB first)
//   busy_o            high in SHIFT and DONE
//   done_o            one-cycle pulse after the last bit
//   state_o           FSM state for debug (0 IDLE, 1 SHIFT, 2 DONE)
module shift_sched #(
  parameter int WIDTH = 5
) (
  input  logic             clk160_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic             grant_o,
  output logic             sen_o,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  // The counter must reach WIDTH when the parity bit is appended.
  localparam int CW = $clog2(WIDTH + 2);
`ifdef SHIFT_SCHED_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             last_q;   // requester granted most recently
  logic             grant_q;
  logic             ack0_q, ack1_q;
`ifdef SHIFT_SCHED_PARITY_EN
  logic             par_q;
`endif

  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] win_word;
  logic             accept;

  // On contention, the requester that did not win last time is chosen.
  // A single requester always wins.
  assign any_req  = req0_i | req1_i;
  assign win      = (req0_i & req1_i) ? ~last_q : req1_i;
  assign win_word = win ? data1_i : data0_i;
  assign accept   = (state_q == IDLE) && any_req;

  always_ff @(posedge clk160_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sen_o   = 1'b0;
    sout_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = SHIFT;
      end
      SHIFT: begin
        busy_o = 1'b1;
        sen_o  = 1'b1;
`ifdef SHIFT_SCHED_PARITY_EN
        // The last SHIFT cycle carries the parity bit instead of data.
        sout_o = (cnt_q == CW'(WIDTH)) ? par_q : shreg_q[0];
`else
        sout_o = shreg_q[0];
`endif
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk160_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;   // so requester 0 wins the first contention
      grant_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef SHIFT_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      if (accept) begin
        shreg_q <= win_word;
        cnt_q   <= '0;
        grant_q <= win;
        last_q  <= win;
        ack0_q  <= ~win;
        ack1_q  <= win;
`ifdef SHIFT_SCHED_PARITY_EN
        par_q   <= ^win_word;
`endif
      end else if (state_q == SHIFT) begin
        shreg_q <= shreg_q >> 1;
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  assign ack0_o  = ack0_q;
  assign ack1_o  = ack1_q;
  assign grant_o = grant_q;
  assign state_o = state_q;

endmodule
